// File: rtl/mmio_bridge.sv
// mmio_bridge: valid/ready bridge from the core load/store path to the data
// memory and NUM_CH switch/LED channels.
//
// Ports:
//   clock, rst                  rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (accept = valid && ready)
//   req_write/req_addr/req_wdata  store flag, byte address, store data
//   rsp_valid/rsp_rdata/rsp_err   one-cycle response strobe, load data, error
//   mem_we/mem_addr/mem_wdata   data memory write enable, address, write data
//   mem_rdata                   data memory read data (MEM_LAT-cycle latency)
//   sw_in                       raw asynchronous switches, CH_W bits per channel
//   led_out                     registered LED drive, CH_W bits per channel
//
// IO map (off = req_addr - IO_BASE): channel = off >> 3, off[2] = 0 selects the
// LED register (read/write), off[2] = 1 the synchronised switches (read-only).
module mmio_bridge #(
   parameter int unsigned          DATA_W      = 32,
   parameter int unsigned          ADDR_W      = 32,
   parameter logic [ADDR_W-1:0]    IO_BASE     = ADDR_W'(32'hFFFF_FC00),
   parameter int unsigned          NUM_CH      = 2,
   parameter int unsigned          CH_W        = 16,
   parameter int unsigned          MEM_LAT     = 1,
   parameter int unsigned          SYNC_STAGES = 2
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic [NUM_CH*CH_W-1:0]   sw_in,
   output logic [NUM_CH*CH_W-1:0]   led_out
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with one less than that
   // and the last WAIT cycle is the one that sees zero.
   localparam logic [2:0] WAIT_INIT = 3'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       rdata_q;
   logic                    err_q;
   logic                    rsp_mem_q;
   logic [CH_W-1:0]         led_q [NUM_CH];
   logic [NUM_CH*CH_W-1:0]  sw_sync [SYNC_STAGES];

   logic [ADDR_W-1:0]       off;
   logic [ADDR_W-1:0]       ch;
   logic                    sel;
   logic                    misaligned;
   logic                    is_io;
   logic                    ch_ok;
   logic                    acc_err;
   logic                    accept;
   logic                    mem_load;
   logic [CH_W-1:0]         io_val;

   // Request decode
   assign req_ready  = !rst && (state_q != WAIT);
   assign accept     = req_valid && req_ready;
   assign off        = req_addr - IO_BASE;
   assign ch         = off >> 3;
   assign sel        = off[2];
   assign misaligned = (req_addr[1:0] != 2'b00);
   assign is_io      = (req_addr >= IO_BASE);
   assign ch_ok      = (ch < ADDR_W'(NUM_CH));
   assign acc_err    = misaligned || (is_io && !ch_ok);
   assign mem_load   = !is_io && !req_write && !misaligned;

   // Memory port: live address on the accept cycle, latched address otherwise
   // so the memory keeps seeing the load address through WAIT and RESP.
   assign mem_we    = accept && req_write && !is_io && !misaligned;
   assign mem_addr  = accept ? req_addr : addr_q;
   assign mem_wdata = req_wdata;

   // Response: memory loads take mem_rdata live in RESP, everything else
   // returns the value captured at accept. Forced to zero outside RESP.
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = !rsp_valid ? '0 : (rsp_mem_q ? mem_rdata : rdata_q);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_led
      assign led_out[g*CH_W +: CH_W] = led_q[g];
   end

   // IO read mux over channels
   always_comb begin
      io_val = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ch == ADDR_W'(i)) begin
            io_val = sel ? sw_sync[SYNC_STAGES-1][i*CH_W +: CH_W] : led_q[i];
         end
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               state_d = (mem_load && (MEM_LAT > 1)) ? WAIT : RESP;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         rsp_mem_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            led_q[i] <= '0;
         end
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sw_sync[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         sw_sync[0] <= sw_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sw_sync[i] <= sw_sync[i-1];
         end
         if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (accept) begin
            addr_q    <= req_addr;
            err_q     <= acc_err;
            rsp_mem_q <= mem_load;
            cnt_q     <= WAIT_INIT;
            rdata_q   <= (is_io && !acc_err && !req_write) ? DATA_W'(io_val) : '0;
            if (is_io && !acc_err && req_write && !sel) begin
               for (int unsigned i = 0; i < NUM_CH; i++) begin
                  if (ch == ADDR_W'(i)) begin
                     led_q[i] <= req_wdata[CH_W-1:0];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed sequences, a vector table and a randomized phase
// checked against a transaction-level model of mmio_bridge.
//
// Ports: none (top-level bench). Drives the bridge with MEM_LAT=3 and
// SYNC_STAGES=3, and supplies a synchronous-read data memory.
module tb_mmio_bridge;

   localparam int unsigned LAT = 3;
   localparam int          S   = 3;
   localparam int unsigned NCH = 2;
   localparam logic [31:0] IOB = 32'hFFFF_FC00;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [31:0] sw_in = '0;
   logic [31:0] led_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mmio_bridge #(
      .MEM_LAT     (LAT),
      .SYNC_STAGES (S)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .sw_in     (sw_in),
      .led_out   (led_out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous-read data memory (read-before-write)
   logic [31:0] ram [256] = '{default: '0};
   always @(posedge clock) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:2]];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clock);
      #1;
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic single(input string name, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_err,
                         input logic [31:0] exp_rdata, input logic chk_rdata,
                         input logic exp_we);
      drive(1'b1, w, a, d);
      @(negedge clock);
      chk({name, "_ready"}, req_ready, 1'b1);
      chk({name, "_we"}, mem_we, exp_we);
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk({name, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({name, "_err"}, rsp_err, exp_err);
      if (chk_rdata) chk({name, "_rdata"}, rsp_rdata, exp_rdata);
   endtask

   task automatic mem_load(input string name, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b1, 1'b0, a, '0);
      @(negedge clock);
      chk({name, "_ready"}, req_ready, 1'b1);
      for (int k = 1; k < int'(LAT); k++) begin
         drive(1'b0, 1'b0, '0, '0);
         @(negedge clock);
         chk({name, "_wait_ready"}, req_ready, 1'b0);
         chk({name, "_wait_rsp"}, rsp_valid, 1'b0);
      end
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk({name, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({name, "_rdata"}, rsp_rdata, exp);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      logic        we;
      logic [31:0] led;
   } vec_t;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] data;
      logic        chk;
   } rsp_t;

   vec_t        tbl [14];
   rsp_t        exp_q [$];
   logic [31:0] hist [int];
   logic [31:0] m_mem [logic [31:0]];
   logic [15:0] m_led [NCH];
   int          r0;

   function automatic logic [15:0] sw_seen(input int c, input int unsigned ch);
      logic [31:0] v;
      v = (c - S >= r0) ? hist[c - S] : 32'h0;
      return v[ch*16 +: 16];
   endfunction

   initial begin
      int          c;
      int          ready_at;
      logic        acc, mis, io, err, sel, exp_rv;
      int unsigned ch, lat;
      logic [31:0] off;
      rsp_t        e;

      tbl[0]  = '{1'b1, IOB,          32'hFFFF_0F0F, 1'b0, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[1]  = '{1'b0, IOB,          32'h0,         1'b0, 32'h0000_0F0F, 1'b0, 32'h3C3C_0F0F};
      tbl[2]  = '{1'b0, IOB + 32'h8,  32'h0,         1'b0, 32'h0000_3C3C, 1'b0, 32'h3C3C_0F0F};
      tbl[3]  = '{1'b0, IOB + 32'h4,  32'h0,         1'b0, 32'h0000_5678, 1'b0, 32'h3C3C_0F0F};
      tbl[4]  = '{1'b1, IOB + 32'h4,  32'h0000_1111, 1'b0, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[5]  = '{1'b1, IOB + 32'h10, 32'h0000_AAAA, 1'b1, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[6]  = '{1'b0, IOB + 32'h10, 32'h0,         1'b1, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[7]  = '{1'b1, IOB + 32'h2,  32'h0000_5555, 1'b1, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[8]  = '{1'b0, IOB + 32'hE,  32'h0,         1'b1, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[9]  = '{1'b1, 32'h0000_0042, 32'h1,        1'b1, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[10] = '{1'b1, 32'h0000_0080, 32'h77,       1'b0, 32'h0,         1'b1, 32'h3C3C_0F0F};
      tbl[11] = '{1'b0, IOB + 32'h3F8, 32'h0,        1'b1, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[12] = '{1'b1, IOB + 32'hC,  32'h0000_9999, 1'b0, 32'h0,         1'b0, 32'h3C3C_0F0F};
      tbl[13] = '{1'b0, IOB + 32'hC,  32'h0,         1'b0, 32'h0000_1234, 1'b0, 32'h3C3C_0F0F};

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_led", led_out, 32'h0);
      chk("rst_mem_we", mem_we, 1'b0);
      @(posedge clock);
      #1 rst = 1'b0;
      @(negedge clock);
      chk("ready_after_rst", req_ready, 1'b1);

      // LED write, single response pulse
      single("led_wr", 1'b1, IOB, 32'h0000_A5A5, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("led_wr_led", led_out, 32'h0000_A5A5);
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk("led_wr_one_pulse", rsp_valid, 1'b0);

      // Switch synchroniser depth: S-1 cycles after a change the old value is read
      drive(1'b0, 1'b0, '0, '0);
      sw_in = 32'hBEEF_0001;
      repeat (S - 2) drive(1'b0, 1'b0, '0, '0);
      single("sw_early", 1'b0, IOB + 32'hC, '0, 1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, '0, '0);
      sw_in = 32'h1234_5678;
      repeat (S - 1) drive(1'b0, 1'b0, '0, '0);
      single("sw_ch1", 1'b0, IOB + 32'hC, '0, 1'b0, 32'h0000_1234, 1'b1, 1'b0);
      single("sw_ch0", 1'b0, IOB + 32'h4, '0, 1'b0, 32'h0000_5678, 1'b1, 1'b0);

      // MEM_LAT=3 load with requests presented during WAIT that must be ignored
      single("st40", 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 32'h40, '0);
      @(negedge clock);
      chk("ld40_ready", req_ready, 1'b1);
      chk("ld40_maddr0", mem_addr, 32'h40);
      for (int k = 1; k < 3; k++) begin
         drive(1'b1, 1'b1, IOB, 32'h0000_FFFF);
         @(negedge clock);
         chk("ld40_wait_ready", req_ready, 1'b0);
         chk("ld40_wait_rsp", rsp_valid, 1'b0);
         chk("ld40_wait_maddr", mem_addr, 32'h40);
         chk("ld40_wait_we", mem_we, 1'b0);
      end
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk("ld40_rsp_valid", rsp_valid, 1'b1);
      chk("ld40_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("ld40_err", rsp_err, 1'b0);
      chk("ld40_maddr3", mem_addr, 32'h40);
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk("ld40_one_pulse", rsp_valid, 1'b0);
      chk("ld40_led_kept", led_out, 32'h0000_A5A5);

      // Back-to-back: memory store, IO read, LED write
      drive(1'b1, 1'b1, 32'h10, 32'hCAFE_0001);
      @(negedge clock);
      chk("b2b_we0", mem_we, 1'b1);
      chk("b2b_maddr", mem_addr, 32'h10);
      chk("b2b_wdata", mem_wdata, 32'hCAFE_0001);
      drive(1'b1, 1'b0, IOB, '0);
      @(negedge clock);
      chk("b2b_we1", mem_we, 1'b0);
      chk("b2b_rsp1", rsp_valid, 1'b1);
      chk("b2b_ready1", req_ready, 1'b1);
      drive(1'b1, 1'b1, IOB + 32'h8, 32'h0000_3C3C);
      @(negedge clock);
      chk("b2b_we2", mem_we, 1'b0);
      chk("b2b_rsp2", rsp_valid, 1'b1);
      chk("b2b_rdata2", rsp_rdata, 32'h0000_A5A5);
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk("b2b_rsp3", rsp_valid, 1'b1);
      chk("b2b_err3", rsp_err, 1'b0);
      chk("b2b_led", led_out, 32'h3C3C_A5A5);
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk("b2b_end", rsp_valid, 1'b0);
      mem_load("ld10", 32'h10, 32'hCAFE_0001);

      // Vector table of single-cycle accesses
      for (int i = 0; i < 14; i++) begin
         single($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                tbl[i].err, tbl[i].rdata, !tbl[i].wr || tbl[i].err, tbl[i].we);
         chk($sformatf("tbl%0d_led", i), led_out, tbl[i].led);
      end
      mem_load("ld80", 32'h80, 32'h77);

      // Reset during WAIT drops the pending response
      drive(1'b1, 1'b0, 32'h40, '0);
      @(negedge clock);
      drive(1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      @(negedge clock);
      drive(1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      @(negedge clock);
      chk("rstw_ready", req_ready, 1'b1);
      chk("rstw_rsp", rsp_valid, 1'b0);
      chk("rstw_led", led_out, 32'h0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, '0, '0);
         @(negedge clock);
         chk("rstw_no_rsp", rsp_valid, 1'b0);
      end

      // Randomized phase against the transaction-level model
      drive(1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      @(posedge clock);
      #1 rst = 1'b0;
      r0 = cyc;
      ready_at = r0;
      for (int unsigned i = 0; i < NCH; i++) m_led[i] = '0;
      for (int n = 0; n < 600; n++) begin
         if (n > 0) begin
            @(posedge clock);
            #1;
         end
         c = cyc;
         req_valid = (n < 590) && ($urandom_range(9) < 7);
         req_write = $urandom_range(1) == 1;
         req_wdata = $urandom;
         case ($urandom_range(3))
            0, 1:    req_addr = 32'h100 + 32'($urandom_range(15)) * 4;
            2:       req_addr = IOB + 32'($urandom_range(7)) * 4;
            default: req_addr = ($urandom_range(1) == 1 ? IOB : 32'h100) + 32'($urandom_range(3, 1));
         endcase
         if ($urandom_range(5) == 0) sw_in = $urandom;
         hist[c] = sw_in;
         @(negedge clock);

         acc = req_valid && (c >= ready_at);
         mis = req_addr[1:0] != 2'b00;
         io  = req_addr >= IOB;
         off = req_addr - IOB;
         ch  = off / 8;
         sel = ((off / 4) % 2) == 1;
         err = mis || (io && ch >= NCH);

         chk("rnd_ready", req_ready, c >= ready_at);
         chk("rnd_we", mem_we, acc && req_write && !io && !mis);
         if (acc && !io) chk("rnd_maddr", mem_addr, req_addr);
         if (acc && req_write && !io && !mis) chk("rnd_wdata", mem_wdata, req_wdata);
         exp_rv = (exp_q.size() > 0) && (exp_q[0].cyc == c);
         chk("rnd_rsp_valid", rsp_valid, exp_rv);
         if (exp_rv) begin
            e = exp_q.pop_front();
            chk("rnd_err", rsp_err, e.err);
            if (e.chk) chk("rnd_rdata", rsp_rdata, e.data);
         end
         chk("rnd_led", led_out, {m_led[1], m_led[0]});

         if (acc) begin
            lat   = (!io && !req_write && !mis) ? LAT : 1;
            e.cyc = c + int'(lat);
            e.err = err;
            e.data = '0;
            e.chk = !req_write || err;
            if (!err) begin
               if (io && !req_write) begin
                  e.data = {16'h0, sel ? sw_seen(c, ch) : m_led[ch]};
               end else if (!io && !req_write) begin
                  if (m_mem.exists(req_addr)) e.data = m_mem[req_addr];
                  else e.chk = 1'b0;
               end else if (!io) begin
                  m_mem[req_addr] = req_wdata;
               end else if (!sel) begin
                  m_led[ch] = req_wdata[15:0];
               end
            end
            if (lat > 1) ready_at = c + int'(lat);
            exp_q.push_back(e);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
